// File: rtl/ram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader_pkg
// Description : Shared types and helpers for the ram_loader byte-stream RAM
//               writer: the FSM state type, the byte width and a
//               bytes-per-word helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_loader_pkg;

  localparam int BYTE_W = 8;

  // FSM state type: IDLE, LOAD, CHK, DONE
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t CHK  = 2'd2;
  localparam state_t DONE = 2'd3;

  // Bytes per RAM word for a given word width (width is a multiple of 8).
  function automatic int calc_bpw(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Collects bytes little-endian into one RAM word. The first
//               byte of a word lands in bits [7:0]. When the last byte of a
//               word is taken, word_rdy pulses for one cycle with the full
//               word on 'word'.
// Revision    : 1.0 - initial release
// Ports       : clk       - system clock
//               rst_n     - asynchronous active-low reset
//               clr       - synchronous clear of the byte counter
//               byte_en   - accept byte_data this cycle
//               byte_data - incoming byte
//               word_rdy  - registered one-cycle pulse, word complete
//               word      - assembled word (valid while word_rdy = 1)
// ============================================================================
module word_assembler
  import ram_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  byte_en,
  input  logic [BYTE_W-1:0]     byte_data,
  output logic                  word_rdy,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int c_bpw   = calc_bpw(DATA_WIDTH);
  localparam int c_cnt_w = (c_bpw > 1) ? $clog2(c_bpw) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_bpw - 1);

  logic [c_cnt_w-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0] shifted;

  // New bytes enter at the top and move down, so after c_bpw bytes the
  // first one sits in the lowest lane.
  generate
    if (c_bpw > 1) begin : g_wide
      assign shifted = {byte_data, shift_q[DATA_WIDTH-1:BYTE_W]};
    end else begin : g_narrow
      assign shifted = byte_data;
    end
  endgenerate

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rdy_d   = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (byte_en) begin
      shift_d = shifted;
      if (cnt_q == c_last_cnt) begin
        cnt_d = '0;
        rdy_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      rdy_q   <= rdy_d;
    end
  end

  assign word_rdy = rdy_q;
  assign word     = shift_q;

endmodule
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader
// Description : Fills a synchronous single-port RAM with WORDS words taken
//               from a byte stream. Owns the load FSM, the word address and
//               the optional trailing-checksum check.
//               Build option RAM_LOADER_CHECKSUM_EN: when defined, an 8-bit
//               sum of all data bytes is kept and one extra checksum byte is
//               expected; err = ((sum + byte) mod 256 != 0).
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n          - clock, async active-low reset
//               start               - begin/restart a load
//               byte_vld, byte_data - byte stream input
//               we, waddr, wdata    - RAM write port
//               busy, done, err     - load status
// ============================================================================
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int WORDS      = 784
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  byte_vld,
  input  logic [BYTE_W-1:0]     byte_data,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(WORDS - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  asm_en;
  logic                  asm_rdy;
  logic [DATA_WIDTH-1:0] asm_word;
  logic                  last_wr;

`ifdef RAM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] sum_q, sum_d;
  logic              err_q, err_d;
  logic [BYTE_W-1:0] chk_sum;

  // Kept 8 bits wide so the comparison below is truly mod 256.
  assign chk_sum = sum_q + byte_data;
`endif

  // The cycle in which the final word's write is on the port.
  assign last_wr = asm_rdy && (addr_q == c_last_addr);

  word_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start),
    .byte_en  (asm_en),
    .byte_data(byte_data),
    .word_rdy (asm_rdy),
    .word     (asm_word)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    asm_en  = 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    if (start) begin
      state_d = LOAD;
      addr_d  = '0;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum_d   = '0;
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
          if (asm_rdy && !last_wr) begin
            addr_d = addr_q + 1'b1;
          end
          if (last_wr) begin
            // No more data bytes are taken once the final word is out.
`ifdef RAM_LOADER_CHECKSUM_EN
            if (byte_vld) begin
              err_d   = (chk_sum != '0);
              state_d = DONE;
            end else begin
              state_d = CHK;
            end
`else
            state_d = DONE;
`endif
          end else if (byte_vld) begin
            asm_en = 1'b1;
`ifdef RAM_LOADER_CHECKSUM_EN
            sum_d  = chk_sum;
`endif
          end
        end
`ifdef RAM_LOADER_CHECKSUM_EN
        CHK: begin
          if (byte_vld) begin
            err_d   = (chk_sum != '0);
            state_d = DONE;
          end
        end
`endif
        default: begin
          // IDLE and DONE hold until start.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign we    = asm_rdy;
  assign waddr = addr_q;
  assign wdata = asm_word;
  assign busy  = (state_q == LOAD) || (state_q == CHK);
  assign done  = (state_q == DONE);
`ifdef RAM_LOADER_CHECKSUM_EN
  assign err   = err_q;
`else
  assign err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_loader
// Description : Self-checking bench for ram_loader with DATA_WIDTH = 16,
//               ADDR_WIDTH = 2, WORDS = 3. A reference model counts accepted
//               bytes and derives each expected write and status value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_loader;

  localparam int N_WORDS = 3;
  localparam int N_BYTES = 2 * N_WORDS;
`ifdef RAM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        byte_vld;
  logic [7:0]  byte_data;
  logic        we;
  logic [1:0]  waddr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        err;

  ram_loader #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(2),
    .WORDS     (N_WORDS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .byte_vld (byte_vld),
    .byte_data(byte_data),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model: phase 0 idle, 1 loading, 2 awaiting checksum, 3 finished.
  int          m_phase = 0;
  int          m_n     = 0;
  logic [7:0]  m_bytes [N_BYTES];
  int          m_sum   = 0;
  bit          m_err   = 1'b0;
  bit          e_we;
  logic [1:0]  e_addr;
  logic [15:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model over
  // the following posedge, then compare at the next negedge.
  task automatic cyc(input bit s, input bit v, input logic [7:0] d);
    start = s; byte_vld = v; byte_data = d;
    e_we = 1'b0; e_addr = '0; e_data = '0;
    if (s) begin
      m_phase = 1; m_n = 0; m_sum = 0; m_err = 1'b0;
    end else if (m_phase == 1) begin
      if (m_n == N_BYTES) begin
        if (CHK_EN && v) begin
          m_err = ((m_sum + d) % 256) != 0; m_phase = 3;
        end else begin
          m_phase = CHK_EN ? 2 : 3;
        end
      end else if (v) begin
        m_bytes[m_n] = d; m_sum += d; m_n++;
        if (m_n % 2 == 0) begin
          e_we = 1'b1; e_addr = 2'(m_n / 2 - 1);
          e_data = {m_bytes[m_n-1], m_bytes[m_n-2]};
        end
      end
    end else if (m_phase == 2 && v) begin
      m_err = ((m_sum + d) % 256) != 0; m_phase = 3;
    end
    @(negedge clk);
    chk("we", 32'(we), 32'(e_we));
    if (e_we) begin
      chk("waddr", 32'(waddr), 32'(e_addr));
      chk("wdata", 32'(wdata), 32'(e_data));
    end
    chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
    chk("done", 32'(done), 32'(m_phase == 3));
    chk("err",  32'(err),  32'(m_err));
  endtask

  task automatic send_stream(input logic [7:0] b [N_BYTES], input int gap);
    for (int i = 0; i < N_BYTES; i++) begin
      cyc(1'b0, 1'b1, b[i]);
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"},    32'(we),    32'd0);
    chk({tag, "_waddr"}, 32'(waddr), 32'd0);
    chk({tag, "_wdata"}, 32'(wdata), 32'd0);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_done"},  32'(done),  32'd0);
    chk({tag, "_err"},   32'(err),   32'd0);
  endtask

  logic [7:0] stream_a [N_BYTES];
  logic [7:0] stream_b [N_BYTES];

  initial begin
    stream_a = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    stream_b = '{8'h11, 8'hA5, 8'h22, 8'hB6, 8'h33, 8'hC7};
    rst_n = 1'b0; start = 1'b0; byte_vld = 1'b0; byte_data = 8'h00;

    // Reset state.
    #1;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Bytes in IDLE are ignored.
    cyc(1'b0, 1'b1, 8'hFF);
    cyc(1'b0, 1'b1, 8'hEE);
    cyc(1'b0, 1'b0, 8'h00);

    // Normal back-to-back load.
    cyc(1'b1, 1'b0, 8'h00);
    send_stream(stream_a, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);
    if (CHK_EN) begin
      cyc(1'b0, 1'b1, 8'h96);   // 0x6A + 0x96 = 0x100 -> err = 0
      cyc(1'b0, 1'b0, 8'h00);
    end

    // Bytes in DONE are ignored.
    cyc(1'b0, 1'b1, 8'h55);
    cyc(1'b0, 1'b1, 8'hAA);

    // Checksum mismatch cases.
    cyc(1'b1, 1'b0, 8'h00);
    send_stream(stream_a, 0);
    cyc(1'b0, 1'b1, 8'hC1);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    send_stream(stream_a, 0);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'hC0);
    cyc(1'b0, 1'b0, 8'h00);

    // Byte coinciding with start, then restart after 3 bytes.
    cyc(1'b1, 1'b1, 8'hDE);
    cyc(1'b0, 1'b1, 8'h01);
    cyc(1'b0, 1'b1, 8'h02);
    cyc(1'b0, 1'b1, 8'h03);
    cyc(1'b1, 1'b1, 8'h04);
    send_stream(stream_b, 0);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h5A);
    cyc(1'b0, 1'b0, 8'h00);

    // Gapped input.
    cyc(1'b1, 1'b0, 8'h00);
    send_stream(stream_a, 5);
    cyc(1'b0, 1'b1, 8'h96);
    cyc(1'b0, 1'b0, 8'h00);

    // Mid-cycle reset during a partial load.
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h9C);
    cyc(1'b0, 1'b1, 8'h8D);
    cyc(1'b0, 1'b1, 8'h7E);
    start = 1'b0; byte_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    m_phase = 0; m_n = 0; m_sum = 0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 8'h12);

    // Randomized traffic with occasional restarts.
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
